// File: rtl/structure_tensor_window.sv
// 3x3 windowed Lucas-Kanade structure-tensor sums over a streamed gradient frame.
// Five product lanes (xx, yy, xy, xt, yt) share one valid/coordinate pipeline.

module structure_tensor_window_lane #(
  parameter int WIDTH      = 320,
  parameter int PROD_WIDTH = 24,
  parameter int ACC_WIDTH  = 28,
  parameter int AW         = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [PROD_WIDTH-1:0] prod,
  input  logic                         prod_vld,
  input  logic        [AW-1:0]         addr,
  input  logic                         col_vld,
  input  logic                         out_en,
  output logic signed [ACC_WIDTH-1:0]  sum
);
  logic signed [PROD_WIDTH-1:0] lb1 [WIDTH];
  logic signed [PROD_WIDTH-1:0] lb2 [WIDTH];
  logic signed [PROD_WIDTH-1:0] rd1, rd2;
  logic signed [ACC_WIDTH-1:0]  colsum_q, h0, h1;

  function automatic logic signed [ACC_WIDTH-1:0] sx(input logic signed [PROD_WIDTH-1:0] v);
    return {{(ACC_WIDTH-PROD_WIDTH){v[PROD_WIDTH-1]}}, v};
  endfunction

  // Reads see the previous contents; the write of this sample lands at the edge.
  assign rd1 = lb1[addr];
  assign rd2 = lb2[addr];

  always_ff @(posedge clk) begin
    if (prod_vld) begin
      lb1[addr] <= prod;
      lb2[addr] <= rd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colsum_q <= '0;
      h0       <= '0;
      h1       <= '0;
      sum      <= '0;
    end else begin
      if (prod_vld) colsum_q <= sx(prod) + sx(rd1) + sx(rd2);
      if (col_vld) begin
        h0 <= colsum_q;
        h1 <= h0;
      end
      if (out_en) sum <= colsum_q + h0 + h1;
    end
  end
endmodule

module structure_tensor_window #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int GRAD_WIDTH = 12,
  parameter int PROD_WIDTH = 2*GRAD_WIDTH,
  parameter int ACC_WIDTH  = 2*GRAD_WIDTH+4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [GRAD_WIDTH-1:0] grad_x,
  input  logic signed [GRAD_WIDTH-1:0] grad_y,
  input  logic signed [GRAD_WIDTH-1:0] grad_t,
  input  logic                         grad_valid,
  input  logic        [9:0]            pixel_x_in,
  input  logic        [8:0]            pixel_y_in,
  output logic signed [ACC_WIDTH-1:0]  sum_xx,
  output logic signed [ACC_WIDTH-1:0]  sum_yy,
  output logic signed [ACC_WIDTH-1:0]  sum_xy,
  output logic signed [ACC_WIDTH-1:0]  sum_xt,
  output logic signed [ACC_WIDTH-1:0]  sum_yt,
  output logic                         sum_valid,
  output logic        [9:0]            pixel_x_out,
  output logic        [8:0]            pixel_y_out
);
  localparam int NP     = 5;
  localparam int STAGES = 1;
  localparam int AW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [NP-1:0][PROD_WIDTH-1:0] prod_d, prod_q;
  logic [NP-1:0][ACC_WIDTH-1:0]  sums;
  logic [STAGES:0]               vld_pipe;   // [0]=products, [1]=column sums
  logic [9:0]                    x1, x2;
  logic [8:0]                    y1, y2;
  logic                          frame_started;
  logic                          in_ok, out_en;

  assign in_ok = grad_valid && (pixel_x_in < 10'(WIDTH)) && (pixel_y_in < 9'(HEIGHT));

  assign prod_d[0] = grad_x * grad_x;
  assign prod_d[1] = grad_y * grad_y;
  assign prod_d[2] = grad_x * grad_y;
  assign prod_d[3] = grad_x * grad_t;
  assign prod_d[4] = grad_y * grad_t;

  // Border windows and anything before the first (0,0) would read stale line buffers.
  assign out_en = vld_pipe[1] && frame_started && (x2 >= 10'd2) && (y2 >= 9'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe      <= '0;
      prod_q        <= '0;
      x1            <= '0;
      y1            <= '0;
      x2            <= '0;
      y2            <= '0;
      frame_started <= 1'b0;
      sum_valid     <= 1'b0;
      pixel_x_out   <= '0;
      pixel_y_out   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_ok};
      if (in_ok) begin
        prod_q <= prod_d;
        x1     <= pixel_x_in;
        y1     <= pixel_y_in;
        if (pixel_x_in == 10'd0 && pixel_y_in == 9'd0) frame_started <= 1'b1;
      end
      if (vld_pipe[0]) begin
        x2 <= x1;
        y2 <= y1;
      end
      sum_valid <= out_en;
      if (out_en) begin
        pixel_x_out <= x2 - 10'd1;
        pixel_y_out <= y2 - 9'd1;
      end
    end
  end

  for (genvar g = 0; g < NP; g++) begin : g_lane
    structure_tensor_window_lane #(
      .WIDTH(WIDTH), .PROD_WIDTH(PROD_WIDTH), .ACC_WIDTH(ACC_WIDTH), .AW(AW)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .prod    (prod_q[g]),
      .prod_vld(vld_pipe[0]),
      .addr    (x1[AW-1:0]),
      .col_vld (vld_pipe[1]),
      .out_en  (out_en),
      .sum     (sums[g])
    );
  end

  assign sum_xx = sums[0];
  assign sum_yy = sums[1];
  assign sum_xy = sums[2];
  assign sum_xt = sums[3];
  assign sum_yt = sums[4];
endmodule
